ula_op_sequencer: RTL and testbench
===================================

// Module: ula_op_sequencer
// PURPOSE
//  Issuing end of the 6-bit ULA operation interface. Accepts operation requests (opcode, A, B)
//  over a valid/ready port and drives the ULA select, operand and reset lines. Captures
//  O/Cout/Zero one cycle later and returns them over a valid/ready response port.
//  Keeps an accumulator so requests can be chained, and counts completed operations.
// PARAMETERS
//  DATA_W  6  operand/result width; must match the ULA data width
//  OP_W    4  opcode width; must match the ULA select width
//  CNT_W   8  width of the completed-operation counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid && req_ready at the clk edge
//  req_op     in   OP_W    ULA opcode (S encoding)
//  req_a      in   DATA_W  operand A; ignored when req_chain=1
//  req_b      in   DATA_W  operand B
//  req_chain  in   1       1: use the accumulator (last captured O) as A
//  rsp_valid  out  1       result present
//  rsp_ready  in   1       result consumed when rsp_valid && rsp_ready at the clk edge
//  rsp_o      out  DATA_W  captured ULA O
//  rsp_cout   out  1       captured ULA Cout
//  rsp_zero   out  1       captured ULA Zero
//  ula_S      out  OP_W    to ULA select
//  ula_A      out  DATA_W  to ULA operand A
//  ula_B      out  DATA_W  to ULA operand B
//  ula_R      out  1       to ULA reset; 1 forces the ULA outputs to zero
//  ula_O      in   DATA_W  from ULA result
//  ula_Cout   in   1       from ULA carry/borrow (bit DATA_W of the extended result)
//  ula_Zero   in   1       from ULA zero flag
//  op_count   out  CNT_W   number of completed captures, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge, any state)
//   - state=IDLE; rsp_valid=0; rsp_o/rsp_cout/rsp_zero=0.
//   - acc=0; op_count=0; ula_S/A/B=0; ula_R=1.
//   - An in-flight operation or an undelivered response is discarded.
//  States
//   - IDLE: req_ready=1, ula_R=1. On accept, latch op, b, and a_sel=(req_chain ? acc : req_a); go to EXEC.
//   - EXEC: req_ready=0, ula_R=0, ula_S/A/B = latched regs (registered, glitch-free). At the clk edge
//     ending EXEC: rsp_o<=ula_O, rsp_cout<=ula_Cout, rsp_zero<=ula_Zero, acc<=ula_O,
//     op_count<=op_count+1 (wraps to 0); go to RESP.
//   - RESP: rsp_valid=1, ula_R=1, req_ready=rsp_ready.
//     On rsp_ready && !req_valid -> IDLE.
//     On rsp_ready && req_valid -> accept the new request, go directly to EXEC.
//     On !rsp_ready -> stay; rsp_* held stable.
//  Timing
//   - Latency: accept at edge n -> EXEC during cycle n+1 -> rsp_valid=1 from cycle n+2.
//   - Peak throughput: one operation per 2 cycles.
//   - A chained request accepted in RESP uses the acc value just captured (the value on rsp_o).
//  Width and flags
//   - Cout/Zero are taken verbatim from the ULA; no recomputation here.
//   - A chain request before any capture uses acc=0.
//   - Unknown opcodes do not exist: all 2^OP_W codes pass through unchanged.
// TESTING
//  1. Reset, op=0000 A=63 B=1 -> rsp_o=0, rsp_cout=1, rsp_zero=1; rsp_valid at accept+2 cycles.
//  2. op=0001 A=3 B=5 -> rsp_o=62, rsp_cout=1, rsp_zero=0; ula_R=0 only during the EXEC cycle.
//  3. Chain: op=0100 A=5, then two op=0100 with req_chain=1 -> responses 6, 7, 8; op_count=3.
//  4. Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0;
//     on release, the next request is accepted the same cycle.
//  5. Back-to-back: 4 requests, rsp_ready=1 -> one response every 2 cycles, in order.
//  6. rst_n=0 during EXEC -> next cycle: IDLE, rsp_valid=0, ula_R=1, acc=0, op_count=0.
//     With CNT_W=2, 4 ops -> op_count=0 (wrap).

Source files
------------

// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer: issuing side of the ULA operation interface.
// Takes (opcode, A, B) requests over valid/ready and drives the ULA lines for one cycle.
// It captures the ULA result on the following edge and returns it over a valid/ready response port.
// The last captured result is kept as an accumulator, so a request can use it as operand A.
module ula_op_sequencer #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_chain,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_o,
  output logic              rsp_cout,
  output logic              rsp_zero,
  output logic [OP_W-1:0]   ula_S,
  output logic [DATA_W-1:0] ula_A,
  output logic [DATA_W-1:0] ula_B,
  output logic              ula_R,
  input  logic [DATA_W-1:0] ula_O,
  input  logic              ula_Cout,
  input  logic              ula_Zero,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] rsp_o_q;
  logic              rsp_cout_q;
  logic              rsp_zero_q;
  logic              rsp_valid_q;
  logic              ula_r_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_sel_d;

  // Operand A source: the accumulator for chained requests, otherwise the request field
  always_comb begin
    a_sel_d = req_chain ? acc_q : req_a;
  end

  // Request acceptance: free in IDLE, blocked in EXEC, and tied to the response handshake in RESP
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RESP: req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  // Sequencer FSM: latch the operation, drive the ULA for one cycle, capture and hold the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rsp_o_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      ula_r_q     <= 1'b1;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= a_sel_d;
            b_q     <= req_b;
            ula_r_q <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_o_q     <= ula_O;
          rsp_cout_q  <= ula_Cout;
          rsp_zero_q  <= ula_Zero;
          acc_q       <= ula_O;
          cnt_q       <= cnt_q + 1'b1;
          rsp_valid_q <= 1'b1;
          ula_r_q     <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (req_valid) begin
              // acc_q already holds the value on rsp_o, so a chained request here uses it directly
              op_q    <= req_op;
              a_q     <= a_sel_d;
              b_q     <= req_b;
              ula_r_q <= 1'b0;
              state_q <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          ula_r_q     <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_o     = rsp_o_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;
  assign ula_S     = op_q;
  assign ula_A     = a_q;
  assign ula_B     = b_q;
  assign ula_R     = ula_r_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Testbench for ula_op_sequencer.
// A behavioural ULA model sits behind the DUT. Requests come from a constant table, and the
// expected responses for accepted requests are queued and compared as they come back.
// A second instance with CNT_W=2 shares all inputs and covers counter wrap-around.
module tb_ula_op_sequencer;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic       chain;
    logic [5:0] eo;
    logic       ec;
    logic       ez;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_op;
  logic [5:0] req_a;
  logic [5:0] req_b;
  logic       req_chain;
  logic       rsp_ready;

  logic       req_ready, rsp_valid, rsp_cout, rsp_zero, ula_R, ula_Cout, ula_Zero;
  logic [5:0] rsp_o, ula_A, ula_B, ula_O;
  logic [3:0] ula_S;
  logic [7:0] op_count;
  logic [7:0] u1;

  logic       req_ready2, rsp_valid2, rsp_cout2, rsp_zero2, ula_R2, ula_Cout2, ula_Zero2;
  logic [5:0] rsp_o2, ula_A2, ula_B2, ula_O2;
  logic [3:0] ula_S2;
  logic [1:0] op_count2;
  logic [7:0] u2;

  vec_t        tbl [16];
  vec_t        exp_q [$];
  bit          exec_exp;
  bit          just_reset;
  logic [3:0]  ex_op;
  logic [5:0]  ex_a, ex_b, bench_acc;
  int unsigned exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  int          tick_no = 0;

  always #5 clk = ~clk;

  ula_op_sequencer #(.DATA_W(6), .OP_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .ula_S(ula_S), .ula_A(ula_A), .ula_B(ula_B), .ula_R(ula_R),
    .ula_O(ula_O), .ula_Cout(ula_Cout), .ula_Zero(ula_Zero), .op_count(op_count)
  );

  ula_op_sequencer #(.DATA_W(6), .OP_W(4), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_o(rsp_o2), .rsp_cout(rsp_cout2),
    .rsp_zero(rsp_zero2), .ula_S(ula_S2), .ula_A(ula_A2), .ula_B(ula_B2), .ula_R(ula_R2),
    .ula_O(ula_O2), .ula_Cout(ula_Cout2), .ula_Zero(ula_Zero2), .op_count(op_count2)
  );

  // ULA model: returns {zero, cout, o}; the reset line forces everything to zero
  function automatic logic [7:0] ula_f(input logic [3:0] s, input logic [5:0] a,
                                       input logic [5:0] b, input logic r);
    logic [6:0] e;
    case (s)
      4'h0:    e = {1'b0, a} + {1'b0, b};
      4'h1:    e = {1'b0, a} - {1'b0, b};
      4'h2:    e = {1'b0, a & b};
      4'h3:    e = {1'b0, a | b};
      4'h4:    e = {1'b0, a} + 7'd1;
      4'h5:    e = {1'b0, a ^ b};
      4'h6:    e = {1'b0, a} - 7'd1;
      4'h7:    e = {1'b0, ~a};
      default: e = {1'b0, b};
    endcase
    if (r) return 8'd0;
    return {(e[5:0] == 6'd0), e};
  endfunction

  always_comb begin
    u1       = ula_f(ula_S, ula_A, ula_B, ula_R);
    ula_O    = u1[5:0];
    ula_Cout = u1[6];
    ula_Zero = u1[7];
  end

  always_comb begin
    u2        = ula_f(ula_S2, ula_A2, ula_B2, ula_R2);
    ula_O2    = u2[5:0];
    ula_Cout2 = u2[6];
    ula_Zero2 = u2[7];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", nm, act, exp, tick_no);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exec_exp   = 1'b0;
    exp_cnt    = 0;
    bench_acc  = '0;
    just_reset = 1'b1;
  endtask

  // One clock: drive at the falling edge, check 1ns later, then update the expectation model
  task automatic tick(input vec_t v, input logic valid, input logic rready,
                      input logic rst_v, output logic accepted);
    logic exp_rv, exp_rr, hs_req, hs_rsp;
    @(negedge clk);
    rst_n     = rst_v;
    req_valid = valid;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_chain = v.chain;
    rsp_ready = rready;
    #1;
    tick_no++;
    exp_rv = (exp_q.size() != 0) && !exec_exp;
    exp_rr = !exec_exp && ((exp_q.size() == 0) || rready);
    chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
    chk("req_ready", int'(req_ready), int'(exp_rr));
    chk("ula_R", int'(ula_R), int'(!exec_exp));
    chk("op_count", int'(op_count), int'(exp_cnt % 256));
    chk("op_count_w2", int'(op_count2), int'(exp_cnt % 4));
    if (exec_exp) begin
      chk("ula_S", int'(ula_S), int'(ex_op));
      chk("ula_A", int'(ula_A), int'(ex_a));
      chk("ula_B", int'(ula_B), int'(ex_b));
    end
    if (just_reset) begin
      chk("rst_rsp_o", int'(rsp_o), 0);
      chk("rst_rsp_flags", int'({rsp_cout, rsp_zero}), 0);
      chk("rst_ula_SAB", int'({ula_S, ula_A, ula_B}), 0);
      just_reset = 1'b0;
    end
    if (exp_rv) begin
      chk("rsp_o", int'(rsp_o), int'(exp_q[0].eo));
      chk("rsp_cout", int'(rsp_cout), int'(exp_q[0].ec));
      chk("rsp_zero", int'(rsp_zero), int'(exp_q[0].ez));
    end
    accepted = 1'b0;
    if (!rst_v) begin
      model_reset();
    end else begin
      hs_rsp = exp_rv && rready;
      hs_req = valid && exp_rr;
      if (exec_exp) exp_cnt++;
      if (hs_rsp) void'(exp_q.pop_front());
      if (hs_req) begin
        ex_op = v.op;
        ex_a  = v.chain ? bench_acc : v.a;
        ex_b  = v.b;
        exp_q.push_back(v);
        bench_acc = v.eo;
      end
      exec_exp = hs_req;
      accepted = hs_req;
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    int   idx = first;
    int   guard = 0;
    int   last_acc = -1;
    logic a;
    while (((idx <= last) || (exp_q.size() != 0)) && (guard < 200)) begin
      tick(tbl[(idx <= last) ? idx : last], (idx <= last), 1'b1, 1'b1, a);
      guard++;
      if (a) begin
        if (last_acc >= 0) chk("accept_gap", tick_no - last_acc, 2);
        last_acc = tick_no;
        idx++;
      end
    end
    chk("stream_issued", idx, last + 1);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  task automatic drain();
    int   guard = 0;
    logic a;
    while ((exp_q.size() != 0) && (guard < 20)) begin
      tick(tbl[0], 1'b0, 1'b1, 1'b1, a);
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    //         op     a      b      ch    eo     ec    ez
    tbl[0]  = '{4'h0, 6'd63, 6'd1,  1'b0, 6'd0,  1'b1, 1'b1};
    tbl[1]  = '{4'h1, 6'd3,  6'd5,  1'b0, 6'd62, 1'b1, 1'b0};
    tbl[2]  = '{4'h0, 6'd33, 6'd9,  1'b1, 6'd9,  1'b0, 1'b0};
    tbl[3]  = '{4'h4, 6'd5,  6'd0,  1'b0, 6'd6,  1'b0, 1'b0};
    tbl[4]  = '{4'h4, 6'd50, 6'd0,  1'b1, 6'd7,  1'b0, 1'b0};
    tbl[5]  = '{4'h4, 6'd50, 6'd0,  1'b1, 6'd8,  1'b0, 1'b0};
    tbl[6]  = '{4'h2, 6'd42, 6'd15, 1'b0, 6'd10, 1'b0, 1'b0};
    tbl[7]  = '{4'h3, 6'd48, 6'd3,  1'b0, 6'd51, 1'b0, 1'b0};
    tbl[8]  = '{4'h5, 6'd21, 6'd21, 1'b0, 6'd0,  1'b0, 1'b1};
    tbl[9]  = '{4'h1, 6'd10, 6'd10, 1'b0, 6'd0,  1'b0, 1'b1};
    tbl[10] = '{4'h0, 6'd20, 6'd1,  1'b1, 6'd1,  1'b0, 1'b0};
    tbl[11] = '{4'h6, 6'd0,  6'd0,  1'b0, 6'd63, 1'b1, 1'b0};
    tbl[12] = '{4'hF, 6'd7,  6'd33, 1'b0, 6'd33, 1'b0, 1'b0};
    tbl[13] = '{4'h7, 6'd63, 6'd0,  1'b0, 6'd0,  1'b0, 1'b1};
    tbl[14] = '{4'h0, 6'd1,  6'd2,  1'b0, 6'd3,  1'b0, 1'b0};
    tbl[15] = '{4'h1, 6'd9,  6'd4,  1'b0, 6'd5,  1'b0, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_chain = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();

    // Basic add/sub with carry and zero, latency covered by per-tick state model
    run_vecs(0, 1);

    // Chain straight after reset starts from acc=0
    tick(tbl[0], 1'b0, 1'b1, 1'b0, a);
    run_vecs(2, 2);

    // Chained increments
    tick(tbl[0], 1'b0, 1'b1, 1'b0, a);
    run_vecs(3, 5);
    chk("chain_op_count", int'(op_count), 3);

    // Back-to-back stream, one accept every two cycles
    run_vecs(6, 13);

    // Backpressure: response held while the next request waits
    tick(tbl[14], 1'b1, 1'b0, 1'b1, a);
    chk("bp_first_accept", int'(a), 1);
    for (int i = 0; i < 6; i++) begin
      tick(tbl[15], 1'b1, 1'b0, 1'b1, a);
      chk("bp_hold_no_accept", int'(a), 0);
      if (i >= 1) begin
        chk("bp_rsp_o_stable", int'(rsp_o), 3);
        chk("bp_req_ready_low", int'(req_ready), 0);
      end
    end
    tick(tbl[15], 1'b1, 1'b1, 1'b1, a);
    chk("bp_release_same_cycle", int'(a), 1);
    drain();

    // Reset in the middle of EXEC discards the operation and clears acc and counters
    tick(tbl[0], 1'b1, 1'b1, 1'b1, a);
    chk("exec_rst_accept", int'(a), 1);
    tick(tbl[0], 1'b0, 1'b1, 1'b0, a);
    tick(tbl[2], 1'b1, 1'b1, 1'b1, a);
    chk("post_rst_op_count", int'(op_count), 0);
    drain();

    // Counter wrap on the 2-bit instance
    tick(tbl[0], 1'b0, 1'b1, 1'b0, a);
    run_vecs(6, 9);
    chk("wrap_cnt_w2", int'(op_count2), 0);
    chk("cnt_w8_after_4", int'(op_count), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
